// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO storage stage, DEPTH x N, with a registered read port: read latency 1 cycle.
// No write backpressure: a write that arrives while full is dropped and sets sticky overflow.
module fifo_sync_buffer #(
   parameter int N         = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [N-1:0]             wr_data,
   input  logic                     rd_en,
   input  logic                     clr_err,
   output logic [N-1:0]             rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [N-1:0]  mem_q [DEPTH];

   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          almost_full_q, almost_full_d;
   logic          almost_empty_q, almost_empty_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          rd_valid_q, rd_valid_d;
   logic [N-1:0]  rd_data_q, rd_data_d;

   logic          push;
   logic          pop;

   // Acceptance uses start-of-cycle flags; a pop frees a slot for a same-cycle push when full.
   always_comb begin
      pop            = rd_en & ~empty_q;
      push           = wr_en & (~full_q | pop);
      wr_ptr_d       = wr_ptr_q + LW'(push);
      rd_ptr_d       = rd_ptr_q + LW'(pop);
      level_d        = level_q + LW'(push) - LW'(pop);
      full_d         = (level_d == LW'(DEPTH));
      empty_d        = (level_d == '0);
      almost_full_d  = (level_d >= LW'(AF_THRESH));
      almost_empty_d = (level_d <= LW'(AE_THRESH));
      overflow_d     = (overflow_q & ~clr_err) | (wr_en & ~push);
      underflow_d    = (underflow_q & ~clr_err) | (rd_en & empty_q);
      rd_valid_d     = pop;
      rd_data_d      = rd_data_q;
      if (pop) begin
         rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         full_q         <= full_d;
         empty_q        <= empty_d;
         almost_full_q  <= almost_full_d;
         almost_empty_q <= almost_empty_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
         rd_valid_q     <= rd_valid_d;
         rd_data_q      <= rd_data_d;
      end
   end

   // Storage has no reset; rd_data stays X-free because it only loads on a valid pop.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// Directed bench for fifo_sync_buffer (N=8, DEPTH=16, AF=14, AE=2) with hand-computed expectations.
module tb_fifo_sync_buffer;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] level;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   fifo_sync_buffer #(.N(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .clr_err      (clr_err),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 ns after the capturing edge.
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      clr_err = c;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b1, 1'b1);
      rst = 1'b0;

      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ae", almost_empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_rdd", rd_data, 0);

      // Fill with 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         chk("fill_level", level, i);
         chk("fill_af", almost_full, (i >= 14) ? 1 : 0);
         chk("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
         chk("fill_full", full, (i == 16) ? 1 : 0);
      end
      chk("fill_empty", empty, 0);
      chk("fill_ovf", overflow, 0);

      // Dropped write while full
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("drop_ovf", overflow, 1);
      chk("drop_level", level, 16);
      chk("drop_full", full, 1);

      // Drain: 0x01..0x10 in order, 0xAA must never appear
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_rdv", rd_valid, 1);
         chk("drain_rdd", rd_data, i);
         chk("drain_level", level, 16 - i);
         chk("drain_ae", almost_empty, (16 - i <= 2) ? 1 : 0);
      end
      chk("drain_empty", empty, 1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_rdv", rd_valid, 0);
      chk("idle_hold", rd_data, 8'h10);

      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", overflow, 0);

      // Full with simultaneous read and write
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("refill_full", full, 1);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("rw_full_rdv", rd_valid, 1);
      chk("rw_full_rdd", rd_data, 8'h01);
      chk("rw_full_level", level, 16);
      chk("rw_full_ovf", overflow, 0);
      for (int i = 2; i <= 17; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("rw_drain_rdd", rd_data, (i == 17) ? 8'h55 : 8'(i));
         chk("rw_drain_rdv", rd_valid, 1);
      end
      chk("rw_drain_empty", empty, 1);

      // Empty with simultaneous read and write: no fall-through
      step(1'b1, 8'h33, 1'b1, 1'b0);
      chk("rw_empty_rdv", rd_valid, 0);
      chk("rw_empty_unf", underflow, 1);
      chk("rw_empty_level", level, 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rw_empty_rdd", rd_data, 8'h33);
      chk("rw_empty_rdv2", rd_valid, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_unf", underflow, 0);
      // A new error in the same cycle as clear must win
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("setwins_unf", underflow, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_unf2", underflow, 0);

      // Wrap-around: prime 3, then 40 cycles of write+read
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      chk("prime_level", level, 3);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'(8'h83 + i), 1'b1, 1'b0);
         chk("wrap_rdd", rd_data, 8'(8'h80 + i));
         chk("wrap_level", level, 3);
         chk("wrap_rdv", rd_valid, 1);
      end

      // Reset at level 9
      for (int i = 0; i < 6; i++) step(1'b1, 8'hC0, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("pre_rst_level", level, 12);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_level9", level, 9);
      rst = 1'b1;
      step(1'b1, 8'h77, 1'b1, 1'b0);
      rst = 1'b0;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_ae", almost_empty, 1);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_rdv", rd_valid, 0);
      chk("mid_rst_rdd", rd_data, 0);
      chk("mid_rst_unf", underflow, 0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rst_unf", underflow, 1);
      chk("post_rst_rdv", rd_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
